fifo_sb_checker: RTL and testbench
==================================

FIFO_SB_CHECKER -- requirements
Module: fifo_sb_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 4, meaning monitored data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, meaning expected-entry storage depth (power of two, >=2).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port in_vld  in  1  accepted write into monitored FIFO this cycle.
REQ-007 SHALL have port in_data  in  DATA_W  write data accompanying in_vld.
REQ-008 SHALL have port out_vld  in  1  accepted read from monitored FIFO this cycle.
REQ-009 SHALL have port out_data  in  DATA_W  read data accompanying out_vld.
REQ-010 SHALL have port count  out  $clog2(DEPTH+1)  current number of expected entries held.
REQ-011 SHALL have port mismatch  out  1  one-cycle pulse: read data differed from expected.
REQ-012 SHALL have port underflow  out  1  one-cycle pulse: read with no expected entry.
REQ-013 SHALL have port overflow  out  1  one-cycle pulse: write dropped, storage full.
REQ-014 SHALL have port err_sticky  out  1  set on any error, held until reset.
REQ-015 SHALL have port err_cnt  out  8  saturating count of error events.
REQ-016 SHALL have port exp_data  out  DATA_W  expected value of first mismatch.
REQ-017 SHALL have port act_data  out  DATA_W  actual value of first mismatch.

Function
REQ-018 SHALL store in_data at write pointer on in_vld when count<DEPTH, or when count==DEPTH and out_vld is high.
REQ-019 SHALL, on out_vld with count>0, compare out_data against entry at read pointer and advance read pointer.
REQ-020 SHALL wrap both pointers modulo DEPTH; no storage clear on pop.
REQ-021 SHALL update count: +1 push only, -1 pop only, unchanged on push+pop or idle.
REQ-022 SHALL drive mismatch, underflow, overflow as registered pulses one cycle after the triggering edge-sampled inputs.
REQ-023 SHALL flag underflow when out_vld with count==0; no compare, read pointer unchanged; a simultaneous in_vld still pushes (no bypass).
REQ-024 SHALL flag overflow when in_vld, count==DEPTH, out_vld low; data dropped, pointers unchanged.
REQ-025 SHALL, with count==DEPTH and both valids high, pop-compare then push in the same cycle; no overflow.
REQ-026 SHALL increment err_cnt by the number of error pulses asserted that cycle (max 1 per cycle: errors mutually exclusive by construction except none), saturating at 255.
REQ-027 SHALL set err_sticky the cycle any error pulse asserts.

Reset
REQ-028 SHALL, while rst high at clk edge, zero pointers, count, all pulse outputs, err_sticky, err_cnt, exp_data, act_data.
REQ-029 SHALL treat rst mid-operation as discarding all pending expected entries; inputs ignored during reset cycle.
REQ-030 SHALL not require storage array reset; stale contents never compared since count==0.

Configuration
REQ-031 SHALL use macro FIFO_SB_ERR_CAPTURE_EN to include first-mismatch capture.
REQ-032 SHALL, with FIFO_SB_ERR_CAPTURE_EN defined, load exp_data/act_data on the first mismatch after reset and hold them until reset.
REQ-033 SHALL, without FIFO_SB_ERR_CAPTURE_EN, keep exp_data/act_data ports and drive them constant zero.

Verification (DATA_W=4, DEPTH=8)
REQ-034 SHALL cover: push 3,7,A then pop 3,7,A -> no error pulses, count 3 then 0, err_cnt 0.
REQ-035 SHALL cover: push 5, pop with out_data 6 -> mismatch pulse one cycle later, err_sticky 1, err_cnt 1, exp_data 5 / act_data 6 when macro defined.
REQ-036 SHALL cover: out_vld with count 0 and in_vld data 9 -> underflow pulse, count 1; next pop of 9 -> no error.
REQ-037 SHALL cover: push 0..7 then push 8 alone -> overflow pulse, count 8; then push F with pop 0 -> no error, count 8, later pops 1..7,F clean.
REQ-038 SHALL cover: 20 pushes/pops cycling pointers through wrap twice -> all compares clean, count returns 0.
REQ-039 SHALL cover: 4 pushes, rst for one cycle, pop any value -> underflow pulse, err_cnt 1 (prior entries discarded).

Source files
------------

// File: rtl/fifo_sb_checker.sv
// Purpose: scoreboard that mirrors a monitored FIFO and checks its read data against what was written.
// Latency: error pulses are registered and appear one cycle after the offending write or read.
// Backpressure: none; passive monitor that observes accepted transfers only and never stalls them.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_vld / in_data      accepted write into the monitored FIFO
//   out_vld / out_data    accepted read from the monitored FIFO
//   count                 number of expected entries currently held
//   mismatch              pulse: read data differed from the expected entry
//   underflow             pulse: read seen with no expected entry
//   overflow              pulse: write dropped because storage was full
//   err_sticky, err_cnt   sticky error flag, saturating error-event count
//   exp_data / act_data   first-mismatch capture (expected / actual)
//
// Build option: define FIFO_SB_ERR_CAPTURE_EN to enable first-mismatch capture;
// otherwise exp_data/act_data are tied to zero.
module fifo_sb_checker #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       out_vld,
  input  logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       mismatch,
  output logic                       underflow,
  output logic                       overflow,
  output logic                       err_sticky,
  output logic [7:0]                 err_cnt,
  output logic [DATA_W-1:0]          exp_data,
  output logic [DATA_W-1:0]          act_data
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] rd_dat;

  logic is_full;
  logic is_empty;
  logic do_push;
  logic do_pop;
  logic mismatch_nxt;
  logic underflow_nxt;
  logic overflow_nxt;
  logic err_any;

  assign rd_dat   = mem[rd_ptr];
  assign is_full  = (count == FULL_CNT);
  assign is_empty = (count == '0);

  // A full store still accepts a write when a read frees a slot in the same cycle.
  // A read against an empty store never pops, even if a write lands this cycle.
  assign do_pop        = out_vld && !is_empty;
  assign do_push       = in_vld && (!is_full || out_vld);
  assign underflow_nxt = out_vld && is_empty;
  assign overflow_nxt  = in_vld && is_full && !out_vld;
  assign mismatch_nxt  = do_pop && (rd_dat != out_data);
  // The three error conditions are mutually exclusive, so at most one event per cycle.
  assign err_any       = mismatch_nxt || underflow_nxt || overflow_nxt;

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      mismatch   <= 1'b0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
      mismatch  <= mismatch_nxt;
      underflow <= underflow_nxt;
      overflow  <= overflow_nxt;
      if (err_any) begin
        err_sticky <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

`ifdef FIFO_SB_ERR_CAPTURE_EN
  logic cap_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_done <= 1'b0;
      exp_data <= '0;
      act_data <= '0;
    end else if (mismatch_nxt && !cap_done) begin
      cap_done <= 1'b1;
      exp_data <= rd_dat;
      act_data <= out_data;
    end
  end
`else
  assign exp_data = '0;
  assign act_data = '0;
`endif

endmodule

// File: tb/tb_fifo_sb_checker.sv
// Purpose: self-checking bench for fifo_sb_checker (DATA_W=4, DEPTH=8).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus drives accepted transfers directly.
module tb_fifo_sb_checker;

  localparam int DW = 4;
  localparam int DP = 8;

  logic          clk;
  logic          rst;
  logic          in_vld;
  logic [DW-1:0] in_data;
  logic          out_vld;
  logic [DW-1:0] out_data;
  logic [3:0]    count;
  logic          mismatch;
  logic          underflow;
  logic          overflow;
  logic          err_sticky;
  logic [7:0]    err_cnt;
  logic [DW-1:0] exp_data;
  logic [DW-1:0] act_data;

  fifo_sb_checker #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_data(in_data),
    .out_vld(out_vld), .out_data(out_data),
    .count(count), .mismatch(mismatch), .underflow(underflow), .overflow(overflow),
    .err_sticky(err_sticky), .err_cnt(err_cnt),
    .exp_data(exp_data), .act_data(act_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Reference model: a plain queue of expected values plus error bookkeeping.
  logic [DW-1:0] m_q[$];
  logic          m_mm, m_uf, m_of, m_sticky, m_cap;
  int            m_errs;
  logic [DW-1:0] m_exp, m_act;

  typedef struct {
    logic          iv;
    logic [DW-1:0] di;
    logic          ov;
    logic [DW-1:0] dq;
    int            e_cnt;
    logic          e_mm;
    logic          e_uf;
    logic          e_of;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int req);
    tot_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mm = 0; m_uf = 0; m_of = 0; m_sticky = 0; m_cap = 0;
    m_errs = 0; m_exp = '0; m_act = '0;
  endtask

  task automatic model_step(input logic iv, input logic [DW-1:0] di,
                            input logic ov, input logic [DW-1:0] dq);
    int n0;
    logic [DW-1:0] e;
    n0   = m_q.size();
    m_uf = ov && (n0 == 0);
    m_of = iv && (n0 == DP) && !ov;
    m_mm = 0;
    if (ov && n0 > 0) begin
      e = m_q.pop_front();
      if (e != dq) begin
        m_mm = 1;
`ifdef FIFO_SB_ERR_CAPTURE_EN
        if (!m_cap) begin m_cap = 1; m_exp = e; m_act = dq; end
`endif
      end
    end
    if (iv && (n0 < DP || ov)) m_q.push_back(di);
    if (m_mm || m_uf || m_of) begin
      m_sticky = 1;
      if (m_errs < 255) m_errs++;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"},      int'(count),      m_q.size());
    chk({tag, ".mismatch"},   int'(mismatch),   int'(m_mm));
    chk({tag, ".underflow"},  int'(underflow),  int'(m_uf));
    chk({tag, ".overflow"},   int'(overflow),   int'(m_of));
    chk({tag, ".err_sticky"}, int'(err_sticky), int'(m_sticky));
    chk({tag, ".err_cnt"},    int'(err_cnt),    m_errs);
    chk({tag, ".exp_data"},   int'(exp_data),   int'(m_exp));
    chk({tag, ".act_data"},   int'(act_data),   int'(m_act));
  endtask

  task automatic step(input string tag, input logic iv, input logic [DW-1:0] di,
                      input logic ov, input logic [DW-1:0] dq);
    @(negedge clk);
    rst = 0; in_vld = iv; in_data = di; out_vld = ov; out_data = dq;
    model_step(iv, di, ov, dq);
    @(posedge clk); #1;
    check_model(tag);
  endtask

  // One reset cycle with busy inputs that must be ignored.
  task automatic reset_cycle(input string tag);
    @(negedge clk);
    rst = 1; in_vld = 1; in_data = 4'hC; out_vld = 1; out_data = 4'h3;
    model_reset();
    @(posedge clk); #1;
    check_model(tag);
  endtask

  task automatic add(input logic iv, input logic [DW-1:0] di, input logic ov,
                     input logic [DW-1:0] dq, input int c, input logic mm,
                     input logic uf, input logic of);
    vec_t v;
    v.iv = iv; v.di = di; v.ov = ov; v.dq = dq;
    v.e_cnt = c; v.e_mm = mm; v.e_uf = uf; v.e_of = of;
    vecs.push_back(v);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          iv, ov;

    // Directed table with hand-derived expectations.
    // Push 3,7,A then pop them back: clean.
    add(1, 4'h3, 0, 4'h0, 1, 0, 0, 0);
    add(1, 4'h7, 0, 4'h0, 2, 0, 0, 0);
    add(1, 4'hA, 0, 4'h0, 3, 0, 0, 0);
    add(0, 4'h0, 1, 4'h3, 2, 0, 0, 0);
    add(0, 4'h0, 1, 4'h7, 1, 0, 0, 0);
    add(0, 4'h0, 1, 4'hA, 0, 0, 0, 0);
    // Push 5, read 6: mismatch.
    add(1, 4'h5, 0, 4'h0, 1, 0, 0, 0);
    add(0, 4'h0, 1, 4'h6, 0, 1, 0, 0);
    // Read while empty with write of 9: underflow, 9 still stored, then clean pop.
    add(1, 4'h9, 1, 4'h1, 1, 0, 1, 0);
    add(0, 4'h0, 1, 4'h9, 0, 0, 0, 0);
    // Fill with 0..7, overflow on 8, full push+pop, drain 1..7,F.
    for (int i = 0; i < 8; i++) add(1, 4'(i), 0, 4'h0, i + 1, 0, 0, 0);
    add(1, 4'h8, 0, 4'h0, 8, 0, 0, 1);
    add(1, 4'hF, 1, 4'h0, 8, 0, 0, 0);
    for (int i = 1; i < 8; i++) add(0, 4'h0, 1, 4'(i), 8 - i, 0, 0, 0);
    add(0, 4'h0, 1, 4'hF, 0, 0, 0, 0);

    rst = 1; in_vld = 0; in_data = '0; out_vld = 0; out_data = '0;
    model_reset();
    @(posedge clk); #1;
    check_model("reset");

    foreach (vecs[k]) begin
      step($sformatf("vec%0d", k), vecs[k].iv, vecs[k].di, vecs[k].ov, vecs[k].dq);
      chk($sformatf("vec%0d.tbl_count", k), int'(count), vecs[k].e_cnt);
      chk($sformatf("vec%0d.tbl_mm", k), int'(mismatch), int'(vecs[k].e_mm));
      chk($sformatf("vec%0d.tbl_uf", k), int'(underflow), int'(vecs[k].e_uf));
      chk($sformatf("vec%0d.tbl_of", k), int'(overflow), int'(vecs[k].e_of));
    end
    chk("tbl.err_cnt_end", int'(err_cnt), 3);

    // Pointer wrap twice: keep 3 in flight, 20 simultaneous push/pop cycles.
    reset_cycle("wrap_rst");
    for (int i = 0; i < 3; i++) step("wrap_fill", 1, 4'(i), 0, 4'h0);
    for (int i = 3; i < 23; i++) step("wrap", 1, 4'(i), 1, 4'(i - 3));
    for (int i = 20; i < 23; i++) step("wrap_drain", 0, 4'h0, 1, 4'(i));
    chk("wrap.count_end", int'(count), 0);
    chk("wrap.err_cnt", int'(err_cnt), 0);

    // Reset discards pending entries: the next read underflows.
    for (int i = 0; i < 4; i++) step("rstmid_fill", 1, 4'(i + 2), 0, 4'h0);
    reset_cycle("rstmid_rst");
    step("rstmid_pop", 0, 4'h0, 1, 4'h2);
    chk("rstmid.underflow", int'(underflow), 1);
    chk("rstmid.err_cnt", int'(err_cnt), 1);

    // Randomised traffic, read data mostly correct.
    reset_cycle("rand_rst");
    for (int i = 0; i < 500; i++) begin
      iv = ($urandom_range(0, 99) < 55);
      ov = ($urandom_range(0, 99) < 50);
      d  = 4'($urandom);
      if (m_q.size() > 0 && $urandom_range(0, 9) != 0) out_data = m_q[0];
      else out_data = 4'($urandom);
      step("rand", iv, d, ov, out_data);
    end

    // Error counter saturation via repeated underflow.
    reset_cycle("sat_rst");
    for (int i = 0; i < 260; i++) step("sat", 0, 4'h0, 1, 4'h0);
    chk("sat.err_cnt", int'(err_cnt), 255);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
